game_screen_sequencer: RTL and testbench
========================================

Name: game_screen_sequencer

Overview:
- Top-level screen-mode controller for the start / game-over overlay printer.
- Generates the `start` and `game_over` mode levels the printer consumes, from the player button and the game-logic collision flag.
- Commits every mode change only at end-of-frame, so a screen is never torn mid-frame.
- Owns the start-text blink and the game-over hold timer, and produces the final overlay pixel-enable from the printer's `en_start_game` / `en_game_over`.

Parameters:
- PIXEL_DISPLAY_BIT, 9, MSB index of X/Y scan counters (width = PIXEL_DISPLAY_BIT+1).
- H_LAST, 799, last X value of a scan line.
- V_LAST, 524, last Y value of a frame.
- BLINK_FRAMES, 30, frames per blink half-period of start text (1..255).
- GAMEOVER_FRAMES, 120, frames the game-over screen is held before a button press is accepted (1..255).

Ports:
- clock_25  input  1  pixel clock, 25 MHz.
- reset  input  1  asynchronous, active-low reset.
- X  input  PIXEL_DISPLAY_BIT+1  current scan column.
- Y  input  PIXEL_DISPLAY_BIT+1  current scan row.
- start_button  input  1  raw player button, asynchronous, active-high.
- collision  input  1  game-logic death flag, synchronous to clock_25, single-cycle or level.
- en_start_game  input  1  start-text pixel from printer.
- en_game_over  input  1  game-over-text pixel from printer.
- start  output  1  1 = game running (to printer and game logic).
- game_over  output  1  1 = game-over screen active.
- overlay_en  output  1  overlay pixel to draw this cycle.
- frame_tick  output  1  one-cycle pulse at the last pixel of each frame.
- state  output  2  current mode: 00 IDLE, 01 PLAY, 10 OVER.

Behaviour:
- Reset values (all outputs and registers, asynchronous, active-low): state=IDLE, start=0, game_over=0, overlay_en=0, frame_tick=0, blink_on=1, frame_cnt=0, pend=none, button synchronisers=0.
- Clocking: all logic on posedge clock_25 or negedge reset.
- frame_tick:
  - Registered; equals 1 in the cycle after X==H_LAST && Y==V_LAST is sampled.
  - Latency 1 clock.
- Button path:
  - 2-flop synchroniser, then rising-edge detect.
  - `btn_pulse` lasts 1 cycle per press; a held button produces one pulse only.
- Pending request register `pend` (none / to_play / to_over / to_idle):
  - Set by events; cleared when committed.
  - A later event overwrites an earlier one, except that to_over always wins over to_play.
- Transitions (evaluated on events, committed on frame_tick):
  - IDLE: btn_pulse → pend=to_play.
  - PLAY: collision=1 → pend=to_over. Button ignored.
  - OVER: ignores collision. When frame_cnt ≥ GAMEOVER_FRAMES and btn_pulse → pend=to_idle. A press before the hold expires is discarded, not queued.
  - On a frame_tick with pend≠none: state takes the pending target, pend clears, frame_cnt clears to 0.
  - Event and frame_tick in the same cycle: the event is committed at that same tick.
- Mode outputs (registered, same cycle as the state change):
  - IDLE: start=0, game_over=0.
  - PLAY: start=1, game_over=0.
  - OVER: start=0, game_over=1.
- frame_cnt (8 bit):
  - Increments on frame_tick.
  - Saturates at 255; no wrap.
  - Cleared on each state commit.
- Blink (IDLE only):
  - blink_on toggles when frame_cnt reaches BLINK_FRAMES, and frame_cnt then restarts at 0.
  - blink_on is forced to 1 on entry to IDLE.
- overlay_en (registered, 1-cycle latency from its inputs):
  - IDLE: en_start_game & blink_on.
  - OVER: en_game_over.
  - PLAY: 0.
- Reset mid-frame or mid-hold: immediate return to reset values; no pending request survives reset.
- Unused state encoding 11: recovers to IDLE at the next clock.

Optional Feature:
- Macro: AUTO_RESTART_EN.
- Defined: in OVER, when frame_cnt reaches GAMEOVER_FRAMES, pend=to_idle is set automatically with no press required. A button press after the hold expires is also accepted.
- Undefined: OVER persists until a button press after the hold expires, as described in Behaviour.

Test Plan:
- Reset low mid-frame with a scan generator running → state=00, start=0, game_over=0, overlay_en=0; release reset → after 1 frame, state still 00 and frame_tick pulses once per 800×525 clocks.
- IDLE, press button at Y=100 → state stays 00 until X=799,Y=524 is sampled; next cycle state=01, start=1, frame_tick=1.
- PLAY, collision pulse 1 cycle at mid-frame → state=10, game_over=1, start=0 at the next frame_tick.
- OVER, press at frame 50 (GAMEOVER_FRAMES=120) → ignored, state stays 10; press at frame 121 → state=00 at the following frame_tick.
- IDLE with en_start_game forced 1, BLINK_FRAMES=2 → overlay_en = 1 for 2 frames, 0 for 2 frames, repeating.
- AUTO_RESTART_EN defined, OVER, no press → state=00 exactly at the frame_tick after frame_cnt reaches 120; button held high continuously → exactly one PLAY entry from IDLE.

Source files
------------

// File: rtl/game_screen_sequencer_if.sv
// Screen-sequencer bus: scan position, player/game inputs, printer pixel
// enables in; mode levels, overlay enable, frame tick and state out.
//   master : scan generator / game logic / printer side (drives inputs)
//   slave  : game_screen_sequencer
//   X, Y          scan column / row (PIXEL_DISPLAY_BIT+1 bits)
//   start_button  raw asynchronous player button, active-high
//   collision     game-logic death flag, single-cycle or level
//   en_start_game start-text pixel from printer
//   en_game_over  game-over-text pixel from printer
//   start         1 = game running
//   game_over     1 = game-over screen active
//   overlay_en    overlay pixel to draw this cycle
//   frame_tick    one-cycle pulse after the last pixel of a frame
//   state         current mode: 00 IDLE, 01 PLAY, 10 OVER
interface game_screen_sequencer_if #(
    parameter int unsigned PIXEL_DISPLAY_BIT = 9
);
    logic [PIXEL_DISPLAY_BIT:0] X;
    logic [PIXEL_DISPLAY_BIT:0] Y;
    logic                       start_button;
    logic                       collision;
    logic                       en_start_game;
    logic                       en_game_over;
    logic                       start;
    logic                       game_over;
    logic                       overlay_en;
    logic                       frame_tick;
    logic [1:0]                 state;

    modport master (
        output X, Y, start_button, collision, en_start_game, en_game_over,
        input  start, game_over, overlay_en, frame_tick, state
    );

    modport slave (
        input  X, Y, start_button, collision, en_start_game, en_game_over,
        output start, game_over, overlay_en, frame_tick, state
    );
endinterface

// File: rtl/game_screen_sequencer.sv
// Screen-mode controller for the start / game-over overlay printer.
// Mode changes requested by the button or the collision flag are held in a
// pending register and committed only at end-of-frame, so no screen tears.
// Also owns the start-text blink, the game-over hold timer and the final
// overlay pixel enable.
// Ports:
//   clock_25  25 MHz pixel clock
//   reset     asynchronous, active-low reset
//   bus       game_screen_sequencer_if.slave (see interface header)
// Optional build macro AUTO_RESTART_EN: when defined, the game-over screen
// returns to IDLE by itself once the hold time has elapsed.
module game_screen_sequencer #(
    parameter int unsigned PIXEL_DISPLAY_BIT = 9,
    parameter int unsigned H_LAST            = 799,
    parameter int unsigned V_LAST            = 524,
    parameter int unsigned BLINK_FRAMES      = 30,
    parameter int unsigned GAMEOVER_FRAMES   = 120
) (
    input  logic                    clock_25,
    input  logic                    reset,
    game_screen_sequencer_if.slave  bus
);

    localparam int unsigned XY_W  = PIXEL_DISPLAY_BIT + 1;
    localparam int unsigned CNT_W = 8;

    localparam logic [XY_W-1:0]  X_END     = XY_W'(H_LAST);
    localparam logic [XY_W-1:0]  Y_END     = XY_W'(V_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] BLINK_LIM = CNT_W'(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(GAMEOVER_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'b00,
        PEND_PLAY = 2'b01,
        PEND_OVER = 2'b10,
        PEND_IDLE = 2'b11
    } pend_t;

    state_t           state_q, state_d;
    pend_t            pend_q, pend_d;
    pend_t            ev;
    pend_t            pend_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             blink_q, blink_d;
    logic             start_q, start_d;
    logic             game_over_q, game_over_d;
    logic             overlay_q, overlay_d;
    logic             tick_q;
    logic             btn_meta, btn_sync, btn_prev;
    logic             eof;
    logic             btn_pulse;
    logic             hold_done;

    // Last pixel of the frame is being scanned: the commit point.
    assign eof       = (bus.X == X_END) && (bus.Y == Y_END);
    // One pulse per press, however long the button is held.
    assign btn_pulse = btn_sync & ~btn_prev;
    assign hold_done = (cnt_q >= HOLD_LIM);

    // Button synchroniser and edge-detect history.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= bus.start_button;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // State and output registers.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= PEND_NONE;
            cnt_q       <= '0;
            blink_q     <= 1'b1;
            start_q     <= 1'b0;
            game_over_q <= 1'b0;
            overlay_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            start_q     <= start_d;
            game_over_q <= game_over_d;
            overlay_q   <= overlay_d;
            tick_q      <= eof;
        end
    end

    // Event capture, end-of-frame commit, frame counter, blink and overlay.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        overlay_d = 1'b0;
        ev        = PEND_NONE;
        cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (btn_pulse) begin
                    ev = PEND_PLAY;
                end
                overlay_d = bus.en_start_game & blink_q;
            end
            ST_PLAY: begin
                if (bus.collision) begin
                    ev = PEND_OVER;
                end
            end
            ST_OVER: begin
`ifdef AUTO_RESTART_EN
                if (hold_done) begin
                    ev = PEND_IDLE;
                end
`else
                // Presses before the hold expires are dropped, not queued.
                if (hold_done && btn_pulse) begin
                    ev = PEND_IDLE;
                end
`endif
                overlay_d = bus.en_game_over;
            end
            default: begin
            end
        endcase

        // Newest event replaces the pending one, but a death is never lost
        // to a start request.
        pend_eff = pend_q;
        if ((ev != PEND_NONE) && !((pend_q == PEND_OVER) && (ev == PEND_PLAY))) begin
            pend_eff = ev;
        end
        pend_d = pend_eff;

        if (state_q == ST_BAD) begin
            state_d = ST_IDLE;
            pend_d  = PEND_NONE;
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (eof) begin
            if (pend_eff != PEND_NONE) begin
                pend_d = PEND_NONE;
                cnt_d  = '0;
                case (pend_eff)
                    PEND_PLAY: state_d = ST_PLAY;
                    PEND_OVER: state_d = ST_OVER;
                    default: begin
                        state_d = ST_IDLE;
                        blink_d = 1'b1;
                    end
                endcase
            end else if (state_q == ST_IDLE) begin
                // In IDLE the frame counter times the blink half-period.
                if (cnt_inc == BLINK_LIM) begin
                    blink_d = ~blink_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end

        start_d     = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    assign bus.start      = start_q;
    assign bus.game_over  = game_over_q;
    assign bus.overlay_en = overlay_q;
    assign bus.frame_tick = tick_q;
    assign bus.state      = 2'(state_q);

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed bench for game_screen_sequencer using a shrunk 10x5 scan
// (50 clocks per frame), BLINK_FRAMES=2 and GAMEOVER_FRAMES=120.
module tb_game_screen_sequencer;

    localparam int unsigned PDB    = 9;
    localparam int unsigned HL     = 9;
    localparam int unsigned VL     = 4;
    localparam int          FRAME  = (HL + 1) * (VL + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   sx = 0;
    int   sy = 0;
    int   cyc;
    int   blink_exp [5] = '{0, 1, 1, 0, 0};

    game_screen_sequencer_if #(.PIXEL_DISPLAY_BIT(PDB)) bus ();

    game_screen_sequencer #(
        .PIXEL_DISPLAY_BIT (PDB),
        .H_LAST            (HL),
        .V_LAST            (VL),
        .BLINK_FRAMES      (2),
        .GAMEOVER_FRAMES   (120)
    ) dut (
        .clock_25 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Free-running scan generator, advanced on the falling edge.
    always @(negedge clk) begin
        if (sx == int'(HL)) begin
            sx = 0;
            sy = (sy == int'(VL)) ? 0 : sy + 1;
        end else begin
            sx = sx + 1;
        end
        bus.X = 10'(sx);
        bus.Y = 10'(sy);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the edge that raised frame_tick.
    task automatic wait_tick(output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 200) begin
            step();
            n++;
            if (bus.frame_tick) got = 1'b1;
        end
        if (!got) check("tick_timeout", 0, 1);
    endtask

    task automatic skip_ticks(input int k);
        int c;
        for (int i = 0; i < k; i++) wait_tick(c);
    endtask

    task automatic press_button();
        @(negedge clk);
        bus.start_button = 1'b1;
        repeat (4) @(negedge clk);
        bus.start_button = 1'b0;
    endtask

    task automatic pulse_collision();
        repeat (20) @(negedge clk);
        bus.collision = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.start_button  = 1'b0;
        bus.collision     = 1'b0;
        bus.en_start_game = 1'b1;
        bus.en_game_over  = 1'b1;

        // Reset held mid-frame with the scan running.
        repeat (23) step();
        check("rst_state", int'(bus.state), 0);
        check("rst_start", int'(bus.start), 0);
        check("rst_game_over", int'(bus.game_over), 0);
        check("rst_overlay", int'(bus.overlay_en), 0);
        check("rst_tick", int'(bus.frame_tick), 0);
        @(negedge clk);
        rst_n            = 1'b1;
        bus.en_game_over = 1'b0;

        // Frame period and single-cycle tick.
        wait_tick(cyc);
        wait_tick(cyc);
        check("frame_period", cyc, FRAME);
        check("idle_after_frames", int'(bus.state), 0);
        step();
        check("tick_one_cycle", int'(bus.frame_tick), 0);

        // Blink: two frames on, two frames off (ticks 3..7).
        for (int i = 0; i < 5; i++) begin
            wait_tick(cyc);
            repeat (5) step();
            check("blink", int'(bus.overlay_en), blink_exp[i]);
        end

        // IDLE -> PLAY only at end-of-frame.
        press_button();
        step();
        check("idle_hold_until_eof", int'(bus.state), 0);
        wait_tick(cyc);
        check("play_state", int'(bus.state), 1);
        check("play_start", int'(bus.start), 1);
        check("play_game_over", int'(bus.game_over), 0);
        bus.en_game_over = 1'b1;
        repeat (3) step();
        check("play_overlay", int'(bus.overlay_en), 0);
        bus.en_game_over = 1'b0;

        // Button ignored in PLAY; collision -> OVER at next tick.
        press_button();
        wait_tick(cyc);
        check("play_ignores_button", int'(bus.state), 1);
        pulse_collision();
        step();
        check("collision_deferred", int'(bus.state), 1);
        wait_tick(cyc);
        check("over_state", int'(bus.state), 2);
        check("over_game_over", int'(bus.game_over), 1);
        check("over_start", int'(bus.start), 0);
        repeat (2) step();
        check("over_overlay_off", int'(bus.overlay_en), 0);
        @(negedge clk);
        bus.en_game_over = 1'b1;
        step();
        check("over_overlay_on", int'(bus.overlay_en), 1);
        @(negedge clk);
        bus.en_game_over = 1'b0;

        // Hold timer: presses at frame 50 and 119 dropped, 120 accepted.
        skip_ticks(50);
        press_button();
        wait_tick(cyc);
        check("over_early_press", int'(bus.state), 2);
        skip_ticks(68);
        press_button();
        wait_tick(cyc);
        check("over_press_119", int'(bus.state), 2);
`ifndef AUTO_RESTART_EN
        press_button();
`endif
        wait_tick(cyc);
        check("over_to_idle", int'(bus.state), 0);
        check("idle_game_over", int'(bus.game_over), 0);
        repeat (3) step();
        check("blink_forced_on_entry", int'(bus.overlay_en), 1);

        // Held button: exactly one PLAY entry.
        @(negedge clk);
        bus.start_button = 1'b1;
        wait_tick(cyc);
        check("held_play", int'(bus.state), 1);
        pulse_collision();
        wait_tick(cyc);
        check("held_over", int'(bus.state), 2);
`ifdef AUTO_RESTART_EN
        skip_ticks(120);
        check("auto_hold", int'(bus.state), 2);
        wait_tick(cyc);
        check("auto_idle", int'(bus.state), 0);
        skip_ticks(2);
        check("held_no_replay", int'(bus.state), 0);
`endif
        @(negedge clk);
        bus.start_button = 1'b0;

        // Asynchronous reset mid-hold.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(bus.state), 0);
        check("async_rst_game_over", int'(bus.game_over), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // A pending request does not survive reset.
        wait_tick(cyc);
        press_button();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(cyc);
        check("pend_cleared_by_reset", int'(bus.state), 0);
        check("pend_cleared_start", int'(bus.start), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
